// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of a shared combinational ALU.
// Each requester gets a registered response slot; grants are round-robin or fixed priority.
module alu_arbiter #(
    parameter bit RR_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [3:0]  req0_ctrl,
    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic [31:0] rsp0_result,
    output logic        rsp0_zero,

    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic [3:0]  req1_ctrl,
    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [31:0] rsp1_result,
    output logic        rsp1_zero,

    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_ctrl,
    input  logic [31:0] alu_op,
    input  logic        alu_zero
);

    typedef enum logic {
        GRANT_REQ0 = 1'b0,
        GRANT_REQ1 = 1'b1
    } grant_e;

    grant_e      last_grant_q, last_grant_d;
    logic        run_q;

    logic        rsp0_valid_q, rsp0_valid_d;
    logic [31:0] rsp0_result_q, rsp0_result_d;
    logic        rsp0_zero_q, rsp0_zero_d;
    logic        rsp1_valid_q, rsp1_valid_d;
    logic [31:0] rsp1_result_q, rsp1_result_d;
    logic        rsp1_zero_q, rsp1_zero_d;

    logic        elig0, elig1;
    logic        grant0, grant1;

    // No grant until the first clock edge after reset is released.
    always_comb begin
        elig0  = run_q && req0_valid && (!rsp0_valid_q || rsp0_ready);
        elig1  = run_q && req1_valid && (!rsp1_valid_q || rsp1_ready);
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (elig0 && elig1) begin
            if (RR_EN && (last_grant_q == GRANT_REQ0)) begin
                grant1 = 1'b1;
            end else begin
                grant0 = 1'b1;
            end
        end else begin
            grant0 = elig0;
            grant1 = elig1;
        end
    end

    always_comb begin
        alu_a    = '0;
        alu_b    = '0;
        alu_ctrl = '0;
        if (grant0) begin
            alu_a    = req0_a;
            alu_b    = req0_b;
            alu_ctrl = req0_ctrl;
        end else if (grant1) begin
            alu_a    = req1_a;
            alu_b    = req1_b;
            alu_ctrl = req1_ctrl;
        end
    end

    always_comb begin
        rsp0_valid_d  = rsp0_valid_q;
        rsp0_result_d = rsp0_result_q;
        rsp0_zero_d   = rsp0_zero_q;
        rsp1_valid_d  = rsp1_valid_q;
        rsp1_result_d = rsp1_result_q;
        rsp1_zero_d   = rsp1_zero_q;
        last_grant_d  = last_grant_q;

        if (grant0) begin
            rsp0_valid_d  = 1'b1;
            rsp0_result_d = alu_op;
            rsp0_zero_d   = alu_zero;
            last_grant_d  = GRANT_REQ0;
        end else if (rsp0_valid_q && rsp0_ready) begin
            rsp0_valid_d = 1'b0;
        end

        if (grant1) begin
            rsp1_valid_d  = 1'b1;
            rsp1_result_d = alu_op;
            rsp1_zero_d   = alu_zero;
            last_grant_d  = GRANT_REQ1;
        end else if (rsp1_valid_q && rsp1_ready) begin
            rsp1_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q         <= 1'b0;
            last_grant_q  <= GRANT_REQ1;
            rsp0_valid_q  <= 1'b0;
            rsp0_result_q <= '0;
            rsp0_zero_q   <= 1'b0;
            rsp1_valid_q  <= 1'b0;
            rsp1_result_q <= '0;
            rsp1_zero_q   <= 1'b0;
        end else begin
            run_q         <= 1'b1;
            last_grant_q  <= last_grant_d;
            rsp0_valid_q  <= rsp0_valid_d;
            rsp0_result_q <= rsp0_result_d;
            rsp0_zero_q   <= rsp0_zero_d;
            rsp1_valid_q  <= rsp1_valid_d;
            rsp1_result_q <= rsp1_result_d;
            rsp1_zero_q   <= rsp1_zero_d;
        end
    end

    assign req0_ready  = grant0;
    assign req1_ready  = grant1;
    assign rsp0_valid  = rsp0_valid_q;
    assign rsp0_result = rsp0_result_q;
    assign rsp0_zero   = rsp0_zero_q;
    assign rsp1_valid  = rsp1_valid_q;
    assign rsp1_result = rsp1_result_q;
    assign rsp1_zero   = rsp1_zero_q;

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single combinational `alu` between two requesters, requester 0 (main execute path) and requester 1 (auxiliary address/branch path). Each requester has a valid/ready request channel and a registered valid/ready response channel. The block grants at most one request per cycle and drives the granted operands straight into the ALU. It captures the ALU result and zero flag into that requester's response register. Arbitration is round-robin by default, with a fixed-priority option.

## Interface
- `RR_EN`, default 1: 1 selects round-robin between requesters; 0 selects fixed priority, where requester 0 always wins.
- `clk` input, 1 bit: clock, rising edge.
- `rst_n` input, 1 bit: asynchronous active-low reset.
- `req0_valid` input, 1 bit: requester 0 has an operation.
- `req0_ready` output, 1 bit: requester 0 operation accepted this cycle.
- `req0_a`, `req0_b` input, 32 bits: operands.
- `req0_ctrl` input, 4 bits: ALU operation code.
- `rsp0_valid` output, 1 bit: requester 0 result held.
- `rsp0_ready` input, 1 bit: requester 0 consumes result.
- `rsp0_result` output, 32 bits: registered ALU result.
- `rsp0_zero` output, 1 bit: registered ALU zero flag.
- `req1_*` and `rsp1_*`: identical set for requester 1.
- `alu_a`, `alu_b` output, 32 bits: operands to the ALU.
- `alu_ctrl` output, 4 bits: operation to the ALU.
- `alu_op` input, 32 bits: ALU result.
- `alu_zero` input, 1 bit: ALU zero flag.

## Operation
- ALU op codes: 0000 add, 0001 sub, 0010 sll, 0011 slt, 0100 sltu, 0101 xor, 0110 srl, 0111 sra, 1000 or, 1001 and.
  - Codes 1010–1111 are passed through unchanged. The ALU returns 0 with zero=1 for these, and that is the captured response.
- Eligibility: requester i is eligible when `reqi_valid`=1 and its response slot is free. The slot is free when `rspi_valid`=0, or when `rspi_valid`=1 and `rspi_ready`=1 in the same cycle, so back-to-back operation is allowed.
- Grant with `RR_EN`=1:
  - Only one eligible requester: it is granted.
  - Both eligible: grant the requester not recorded in `last_grant`.
- Grant with `RR_EN`=0: requester 0 wins whenever it is eligible.
- `reqi_ready` = grant_i. It is combinational from valid, ready and the response state. It never depends on `req*_ready`.
- ALU inputs: driven from the granted requester's a/b/ctrl.
  - With no grant, `alu_a`=`alu_b`=0 and `alu_ctrl`=0000.
- On a grant, at the clock edge:
  - `rspi_result` <= `alu_op`, `rspi_zero` <= `alu_zero`, `rspi_valid` <= 1.
  - `last_grant` <= i.
- On `rspi_valid`=1 and `rspi_ready`=1 with no new grant to i: `rspi_valid` <= 0. Result and zero keep their old values.
- Requester protocol: payload must be held stable while valid=1 and ready=0. The block does not check this.
- Response payload is stable while `rspi_valid`=1 and `rspi_ready`=0.

## Timing
- Reset (async assert, sync deassert on the next clk edge):
  - `rsp0_valid`=`rsp1_valid`=0.
  - `rsp*_result`=0, `rsp*_zero`=0.
  - `last_grant`=1, so requester 0 wins the first tie.
  - Combinational outputs follow from this state: `req*_ready`=0 unless valid, and `alu_*` zero when idle.
- Latency: request accepted in cycle N gives `rspi_valid`=1 in cycle N+1.
- Throughput:
  - One operation per cycle in total across both requesters.
  - One operation per cycle per requester if its response is consumed each cycle.
- A response that is never consumed blocks further grants to that requester only. The other requester proceeds every cycle.
- Round-robin guarantees a waiting eligible requester is granted within 2 cycles.
- Reset mid-operation: pending responses are discarded. A request asserted during reset is not granted until after deassert.

## Test plan
- Single op: req0 a=5, b=3, ctrl=0001 → req0_ready=1 that cycle; next cycle rsp0_valid=1, result=2, zero=0.
- Tie, round-robin: both valid every cycle, rsp_ready=1 → grants 0,1,0,1…
  - req0 sra a=0x80000000, b=4 → 0xF8000000.
  - req1 xor a=b=0xA5A5A5A5 → result 0, zero=1.
- Backpressure: rsp0_ready=0 with rsp0_valid=1, req0 valid → req0_ready=0 and rsp0 result held. req1 sltu a=1, b=2 is granted each cycle → result 1.
- Fixed priority (`RR_EN`=0): both valid continuously → req0 granted every cycle, req1 never. Drop req0 → req1 granted the same cycle.
- Illegal ctrl 1111 from req1 → rsp1 result=0, zero=1.
- Reset with rsp0_valid=1 → rsp0_valid=0 immediately. After deassert, a tie grants req0 first.
